// File: rtl/apb_fsm_controller_pkg.sv
// apb_fsm_controller_pkg: shared AHB-to-APB bridge state encoding and peripheral select codes
package apb_fsm_controller_pkg;
   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_WWAIT    = 3'd1;
   localparam logic [2:0] ST_READ     = 3'd2;
   localparam logic [2:0] ST_WRITE    = 3'd3;
   localparam logic [2:0] ST_WRITEP   = 3'd4;
   localparam logic [2:0] ST_RENABLE  = 3'd5;
   localparam logic [2:0] ST_WENABLE  = 3'd6;
   localparam logic [2:0] ST_WENABLEP = 3'd7;
   localparam logic [2:0] PSEL_NONE   = 3'b000;
   localparam logic [2:0] PSEL_0      = 3'b001;
   localparam logic [2:0] PSEL_1      = 3'b010;
   localparam logic [2:0] PSEL_2      = 3'b100;
endpackage

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: AHB-to-APB bridge FSM with registered APB outputs
module apb_fsm_controller
   import apb_fsm_controller_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  Hclk,
   input  logic                  Hreset,
   input  logic                  valid,
   input  logic                  Hwrite,
   input  logic                  Hwrite_reg,
   input  logic [ADDR_WIDTH-1:0] Haddr,
   input  logic [ADDR_WIDTH-1:0] Haddr1,
   input  logic [ADDR_WIDTH-1:0] Haddr2,
   input  logic [DATA_WIDTH-1:0] Hwdata,
   input  logic [DATA_WIDTH-1:0] Hwdata1,
   input  logic [2:0]            temp_selx,
   input  logic                  Pready,
   output logic                  Pwrite,
   output logic                  Penable,
   output logic [2:0]            Pselx,
   output logic [ADDR_WIDTH-1:0] Paddr,
   output logic [DATA_WIDTH-1:0] Pwdata,
   output logic                  Hreadyout
);
   logic [2:0]            state_q, state_d;
   logic                  pwrite_q, pwrite_d;
   logic                  penable_q, penable_d;
   logic [2:0]            pselx_q, pselx_d;
   logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
   logic                  in_enable;

   // next state, then APB outputs loaded according to the state being entered
   always_comb begin
      state_d   = state_q;
      pwrite_d  = pwrite_q;
      penable_d = penable_q;
      pselx_d   = pselx_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      case (state_q)
         ST_IDLE:     state_d = valid ? (Hwrite ? ST_WWAIT : ST_READ) : ST_IDLE;
         ST_WWAIT:    state_d = valid ? ST_WRITEP : ST_WRITE;
         ST_READ:     state_d = ST_RENABLE;
         ST_WRITEP:   state_d = ST_WENABLEP;
         ST_WRITE:    state_d = valid ? ST_WENABLEP : ST_WENABLE;
         ST_RENABLE,
         ST_WENABLE:  state_d = !Pready ? state_q : valid ? (Hwrite ? ST_WWAIT : ST_READ) : ST_IDLE;
         ST_WENABLEP: state_d = !Pready ? state_q : !Hwrite_reg ? ST_READ : valid ? ST_WRITEP : ST_WRITE;
      endcase
      case (state_d)
         ST_READ: begin
            pwrite_d  = 1'b0;
            penable_d = 1'b0;
            pselx_d   = temp_selx;
            paddr_d   = (state_q == ST_WENABLEP) ? Haddr2 : Haddr;
         end
         ST_WRITE, ST_WRITEP: begin
            pwrite_d  = 1'b1;
            penable_d = 1'b0;
            pselx_d   = temp_selx;
            paddr_d   = (state_q == ST_WWAIT) ? Haddr1 : Haddr2;
            pwdata_d  = (state_q == ST_WWAIT) ? Hwdata : Hwdata1;
         end
         ST_RENABLE, ST_WENABLE, ST_WENABLEP: penable_d = 1'b1;
         default: begin
            penable_d = 1'b0;
            pselx_d   = PSEL_NONE;
         end
      endcase
   end

   // state and APB output registers; reset aborts any transfer in flight
   always_ff @(posedge Hclk or posedge Hreset) begin
      if (Hreset) begin
         state_q   <= ST_IDLE;
         pwrite_q  <= 1'b0;
         penable_q <= 1'b0;
         pselx_q   <= PSEL_NONE;
         paddr_q   <= '0;
         pwdata_q  <= '0;
      end else begin
         state_q   <= state_d;
         pwrite_q  <= pwrite_d;
         penable_q <= penable_d;
         pselx_q   <= pselx_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
      end
   end

   assign in_enable = (state_q == ST_RENABLE) || (state_q == ST_WENABLE) || (state_q == ST_WENABLEP);
   assign Hreadyout = !((state_q == ST_READ) || (state_q == ST_WRITEP) || (in_enable && !Pready));
   assign Pwrite    = pwrite_q;
   assign Penable   = penable_q;
   assign Pselx     = pselx_q;
   assign Paddr     = paddr_q;
   assign Pwdata    = pwdata_q;
endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb_apb_fsm_controller: directed table, corner sequences and randomized checks against a phase-level model
module tb_apb_fsm_controller;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;

   logic        Hclk = 1'b0;
   logic        Hreset;
   logic        valid, Hwrite, Hwrite_reg;
   logic [31:0] Haddr, Haddr1, Haddr2, Hwdata, Hwdata1;
   logic [2:0]  temp_selx;
   logic        Pready;
   logic        Pwrite, Penable, Hreadyout;
   logic [2:0]  Pselx;
   logic [31:0] Paddr, Pwdata;

   int n_tests = 0;
   int n_fail  = 0;

   apb_fsm_controller #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Hwrite(Hwrite), .Hwrite_reg(Hwrite_reg),
      .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata(Hwdata), .Hwdata1(Hwdata1),
      .temp_selx(temp_selx), .Pready(Pready), .Pwrite(Pwrite), .Penable(Penable),
      .Pselx(Pselx), .Paddr(Paddr), .Pwdata(Pwdata), .Hreadyout(Hreadyout)
   );

   always #5 Hclk = ~Hclk;

   // Model: a transfer is in phase idle(0), write-wait(1), setup(2) or access(3),
   // with a direction and whether a second write is already pipelined behind it.
   int          m_phase, n_phase;
   logic        m_wr, n_wr, m_pipe, n_pipe;
   logic        e_pwrite, e_pen, x_pwrite, x_pen;
   logic [2:0]  e_psel, x_psel;
   logic [31:0] e_paddr, e_pwdata, x_paddr, x_pwdata;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_hrdy();
      return !((m_phase == 2 && (!m_wr || m_pipe)) || (m_phase == 3 && !Pready));
   endfunction

   task automatic model_reset();
      m_phase = 0; m_wr = 0; m_pipe = 0;
      e_pwrite = 0; e_pen = 0; e_psel = 0; e_paddr = 0; e_pwdata = 0;
   endtask

   task automatic setup(input logic wr, input logic pipe, input logic [31:0] a, input logic [31:0] d);
      n_phase = 2; n_wr = wr; n_pipe = pipe;
      x_paddr = a; if (wr) x_pwdata = d;
      x_pwrite = wr; x_pen = 0; x_psel = temp_selx;
   endtask

   task automatic model_next();
      n_phase = m_phase; n_wr = m_wr; n_pipe = m_pipe;
      x_pwrite = e_pwrite; x_pen = e_pen; x_psel = e_psel; x_paddr = e_paddr; x_pwdata = e_pwdata;
      if (m_phase == 3 && !Pready) begin
      end else if (m_phase == 0 || (m_phase == 3 && !m_pipe)) begin
         if (valid && !Hwrite) setup(0, 0, Haddr, 0);
         else begin
            n_phase = (valid && Hwrite) ? 1 : 0;
            x_pen = 0; x_psel = 0;
         end
      end else if (m_phase == 1) setup(1, valid, Haddr1, Hwdata);
      else if (m_phase == 2) begin
         n_phase = 3; n_pipe = m_wr && (m_pipe || valid); x_pen = 1;
      end else if (!Hwrite_reg) setup(0, 0, Haddr2, 0);
      else setup(1, valid, Haddr2, Hwdata1);
   endtask

   task automatic mcheck();
      chk("m_pwrite", 32'(Pwrite), 32'(e_pwrite));
      chk("m_penable", 32'(Penable), 32'(e_pen));
      chk("m_pselx", 32'(Pselx), 32'(e_psel));
      chk("m_paddr", Paddr, e_paddr);
      chk("m_pwdata", Pwdata, e_pwdata);
      chk("m_hreadyout", 32'(Hreadyout), 32'(m_hrdy()));
   endtask

   // one clock: predict, let the edge happen, shift the AHB delay line, compare
   task automatic step();
      model_next();
      @(posedge Hclk); #1;
      m_phase = n_phase; m_wr = n_wr; m_pipe = n_pipe;
      e_pwrite = x_pwrite; e_pen = x_pen; e_psel = x_psel; e_paddr = x_paddr; e_pwdata = x_pwdata;
      Haddr2 = Haddr1; Haddr1 = Haddr; Hwdata1 = Hwdata; Hwrite_reg = Hwrite;
      mcheck();
   endtask

   task automatic drive(input logic v, input logic hw, input logic [31:0] a, input logic [31:0] d,
                        input logic [2:0] s, input logic r);
      valid = v; Hwrite = hw; Haddr = a; Hwdata = d; temp_selx = s; Pready = r;
   endtask

   task automatic hit_reset();
      #2 Hreset = 1;
      #1;
      chk("rst_pwrite", 32'(Pwrite), 0);
      chk("rst_penable", 32'(Penable), 0);
      chk("rst_pselx", 32'(Pselx), 0);
      chk("rst_paddr", Paddr, 0);
      chk("rst_pwdata", Pwdata, 0);
      chk("rst_hreadyout", 32'(Hreadyout), 1);
      model_reset();
      @(posedge Hclk); #1;
      Hreset = 0;
   endtask

   typedef struct {
      logic v, hw; logic [31:0] a, d; logic [2:0] s; logic r;
      logic [31:0] ea, ed; logic epen; logic [2:0] es; logic ewr, ehr;
   } vec_t;
   vec_t tbl[13];

   initial begin
      tbl[0]  = '{H, L, 32'h8000_0010, 32'h0,         3'b001, H, 32'h8000_0010, 32'h0,         L, 3'b001, L, L};
      tbl[1]  = '{L, L, 32'h0,         32'h0,         3'b000, H, 32'h8000_0010, 32'h0,         H, 3'b001, L, H};
      tbl[2]  = '{L, L, 32'h0,         32'h0,         3'b000, H, 32'h8000_0010, 32'h0,         L, 3'b000, L, H};
      tbl[3]  = '{H, H, 32'h8400_0004, 32'h0,         3'b010, H, 32'h8000_0010, 32'h0,         L, 3'b000, L, H};
      tbl[4]  = '{L, L, 32'h0,         32'hDEAD_BEEF, 3'b010, H, 32'h8400_0004, 32'hDEAD_BEEF, L, 3'b010, H, H};
      tbl[5]  = '{L, L, 32'h0,         32'h0,         3'b000, H, 32'h8400_0004, 32'hDEAD_BEEF, H, 3'b010, H, H};
      tbl[6]  = '{L, L, 32'h0,         32'h0,         3'b000, H, 32'h8400_0004, 32'hDEAD_BEEF, L, 3'b000, H, H};
      tbl[7]  = '{H, H, 32'h8800_0000, 32'h0,         3'b100, H, 32'h8400_0004, 32'hDEAD_BEEF, L, 3'b000, H, H};
      tbl[8]  = '{H, H, 32'h8800_0004, 32'h1111_1111, 3'b100, H, 32'h8800_0000, 32'h1111_1111, L, 3'b100, H, L};
      tbl[9]  = '{L, H, 32'h0,         32'h2222_2222, 3'b100, H, 32'h8800_0000, 32'h1111_1111, H, 3'b100, H, H};
      tbl[10] = '{L, L, 32'h0,         32'h0,         3'b100, H, 32'h8800_0004, 32'h2222_2222, L, 3'b100, H, H};
      tbl[11] = '{L, L, 32'h0,         32'h0,         3'b000, H, 32'h8800_0004, 32'h2222_2222, H, 3'b100, H, H};
      tbl[12] = '{L, L, 32'h0,         32'h0,         3'b000, H, 32'h8800_0004, 32'h2222_2222, L, 3'b000, H, H};

      Hreset = 1;
      drive(0, 0, 0, 0, 0, 1);
      Hwrite_reg = 0; Haddr1 = 0; Haddr2 = 0; Hwdata1 = 0;
      model_reset();
      repeat (2) @(posedge Hclk);
      #1;
      chk("reset_penable", 32'(Penable), 0);
      chk("reset_pselx", 32'(Pselx), 0);
      chk("reset_paddr", Paddr, 0);
      chk("reset_hreadyout", 32'(Hreadyout), 1);
      Hreset = 0;

      for (int i = 0; i < 13; i++) begin
         drive(tbl[i].v, tbl[i].hw, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].r);
         step();
         chk($sformatf("vec%0d_paddr", i), Paddr, tbl[i].ea);
         chk($sformatf("vec%0d_pwdata", i), Pwdata, tbl[i].ed);
         chk($sformatf("vec%0d_penable", i), 32'(Penable), 32'(tbl[i].epen));
         chk($sformatf("vec%0d_pselx", i), 32'(Pselx), 32'(tbl[i].es));
         chk($sformatf("vec%0d_pwrite", i), 32'(Pwrite), 32'(tbl[i].ewr));
         chk($sformatf("vec%0d_hreadyout", i), 32'(Hreadyout), 32'(tbl[i].ehr));
      end

      drive(1, 0, 32'hA000_0020, 0, 3'b001, 1);
      step();
      drive(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_penable", 32'(Penable), 1);
         chk("stall_paddr", Paddr, 32'hA000_0020);
         chk("stall_pselx", 32'(Pselx), 32'(3'b001));
         chk("stall_hreadyout", 32'(Hreadyout), 0);
      end
      Pready = 1;
      #1 chk("stall_release_hreadyout", 32'(Hreadyout), 1);
      step();
      chk("stall_done_penable", 32'(Penable), 0);
      chk("stall_done_pselx", 32'(Pselx), 0);

      drive(1, 1, 32'hC000_0008, 0, 3'b010, 1);
      step();
      drive(0, 0, 0, 32'h1234_5678, 3'b010, 1);
      step();
      chk("pre_rst_pwdata", Pwdata, 32'h1234_5678);
      step();
      chk("pre_rst_penable", 32'(Penable), 1);
      hit_reset();
      drive(1, 0, 32'h8000_0040, 0, 3'b100, 1);
      step();
      chk("post_rst_paddr", Paddr, 32'h8000_0040);
      chk("post_rst_pselx", 32'(Pselx), 32'(3'b100));
      drive(0, 0, 0, 0, 0, 1);
      step();
      chk("post_rst_penable", 32'(Penable), 1);
      step();
      chk("post_rst_idle", 32'(Penable), 0);

      for (int i = 0; i < 600; i++) begin
         logic [2:0] sels [4];
         sels[0] = 3'b000; sels[1] = 3'b001; sels[2] = 3'b010; sels[3] = 3'b100;
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
               sels[$urandom_range(0, 3)], $urandom_range(0, 3) != 0);
         if (i % 150 == 77) hit_reset();
         else step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
